// File: rtl/smart_scales_pkg.sv
// Shared types and widths for the smart scales acquisition path: FSM state
// encoding, sample widths and small arithmetic helpers.
package smart_scales_pkg;

   localparam int W_W = 9;
   localparam int H_W = 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCUM  = 2'd1,
      LOCKED = 2'd2
   } state_t;

   function automatic logic [W_W-1:0] abs_diff(input logic [W_W-1:0] a, input logic [W_W-1:0] b);
      return (a >= b) ? (a - b) : (b - a);
   endfunction

   // Subtraction that clamps at zero instead of wrapping.
   function automatic logic [W_W-1:0] sat_sub(input logic [W_W-1:0] a, input logic [W_W-1:0] b);
      return (a > b) ? (a - b) : {W_W{1'b0}};
   endfunction

endpackage

// File: rtl/smart_scales_frontend_window_averager.sv
// Fixed-length window averager: counts accepted samples, sums weight and height,
// and flags the completing sample combinationally along with the truncated averages.
module window_averager
   import smart_scales_pkg::*;
#(
   parameter int AVG_LOG2 = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sample_en,
   input  logic [W_W-1:0] w_sample,
   input  logic [H_W-1:0] h_sample,
   output logic           win_done,
   output logic [W_W-1:0] w_avg,
   output logic [H_W-1:0] h_avg
);

   localparam int CW = (AVG_LOG2 > 0) ? AVG_LOG2 : 1;
   localparam int WA = W_W + AVG_LOG2;
   localparam int HA = H_W + AVG_LOG2;
   localparam logic [CW-1:0] LAST_C = CW'((1 << AVG_LOG2) - 1);

   logic [CW-1:0] cnt_r;
   logic [WA-1:0] w_acc_r;
   logic [HA-1:0] h_acc_r;
   logic [WA-1:0] w_sum_s;
   logic [HA-1:0] h_sum_s;
   logic          last_s;

   // The completing sample is folded in here so the average is ready on its own cycle.
   assign w_sum_s  = w_acc_r + WA'(w_sample);
   assign h_sum_s  = h_acc_r + HA'(h_sample);
   assign last_s   = (cnt_r == LAST_C);
   assign win_done = sample_en & last_s;
   assign w_avg    = W_W'(w_sum_s >> AVG_LOG2);
   assign h_avg    = H_W'(h_sum_s >> AVG_LOG2);

   // Sample counter and accumulators; a finished window restarts from zero.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt_r   <= {CW{1'b0}};
         w_acc_r <= {WA{1'b0}};
         h_acc_r <= {HA{1'b0}};
      end else if (sample_en) begin
         if (last_s) begin
            cnt_r   <= {CW{1'b0}};
            w_acc_r <= {WA{1'b0}};
            h_acc_r <= {HA{1'b0}};
         end else begin
            cnt_r   <= cnt_r + CW'(1);
            w_acc_r <= w_sum_s;
            h_acc_r <= h_sum_s;
         end
      end
   end

endmodule

// File: rtl/smart_scales_frontend.sv
// Acquisition front end: windowed averaging, settle detection and measurement lock.
// Optional tare support is built when SCALE_TARE_EN is defined.
module smart_scales_frontend
   import smart_scales_pkg::*;
#(
   parameter int AVG_LOG2   = 2,
   parameter int TOL        = 2,
   parameter int STABLE_WIN = 3,
   parameter int EMPTY_TH   = 10
) (
   input  logic           clk,
   input  logic           rst_n,
   input  logic           sample_valid,
   input  logic [W_W-1:0] w_sample,
   input  logic [H_W-1:0] h_sample,
`ifdef SCALE_TARE_EN
   input  logic           tare,
`endif
   output logic [W_W-1:0] weight,
   output logic [H_W-1:0] height,
   output logic           meas_valid,
   output logic           meas_strobe,
   output logic           busy
);

   localparam int MW = $clog2(STABLE_WIN + 1);
   localparam logic [W_W-1:0] EMPTY_TH_C = W_W'(EMPTY_TH);
   localparam logic [W_W-1:0] TOL_C      = W_W'(TOL);
   localparam logic [MW-1:0]  STABLE_C   = MW'(STABLE_WIN);

   state_t         state_r, state_s;
   logic [MW-1:0]  m_r, m_s;
   logic [W_W-1:0] prev_avg_r, prev_avg_s;
   logic           prev_ok_r, prev_ok_s;
   logic [W_W-1:0] weight_r, weight_s;
   logic [H_W-1:0] height_r, height_s;
   logic           meas_valid_r, meas_strobe_r, busy_r;
   logic           strobe_s;
   logic           tare_s, tare_arm_r, tare_arm_s;
   logic [W_W-1:0] tare_off_r, tare_off_s;
   logic           take_s, win_done_s;
   logic [W_W-1:0] w_avg_s, w_eff_s;
   logic [H_W-1:0] h_avg_s;

`ifdef SCALE_TARE_EN
   assign tare_s = tare;
`else
   assign tare_s = 1'b0;
`endif

   // In IDLE only a non-empty sample (or an armed tare capture) enters the averager.
   assign take_s  = (state_r != IDLE) || tare_arm_r || (!tare_s && (w_sample >= EMPTY_TH_C));
   assign w_eff_s = sat_sub(w_avg_s, tare_off_r);

   window_averager #(.AVG_LOG2(AVG_LOG2)) u_avg (
      .clk       (clk),
      .rst_n     (rst_n),
      .sample_en (sample_valid & take_s),
      .w_sample  (w_sample),
      .h_sample  (h_sample),
      .win_done  (win_done_s),
      .w_avg     (w_avg_s),
      .h_avg     (h_avg_s)
   );

   // Next-state, match counting and lock decisions.
   always_comb begin
      state_s    = state_r;
      m_s        = m_r;
      prev_avg_s = prev_avg_r;
      prev_ok_s  = prev_ok_r;
      weight_s   = weight_r;
      height_s   = height_r;
      strobe_s   = 1'b0;
      tare_arm_s = tare_arm_r;
      tare_off_s = tare_off_r;
      case (state_r)
         IDLE: begin
            if (tare_arm_r) begin
               if (win_done_s) begin
                  tare_off_s = w_avg_s;
                  tare_arm_s = 1'b0;
               end else begin
                  tare_arm_s = 1'b1;
               end
            end else if (tare_s) begin
               tare_arm_s = 1'b1;
            end else if (sample_valid && take_s) begin
               state_s   = ACCUM;
               m_s       = {MW{1'b0}};
               prev_ok_s = 1'b0;
            end else begin
               state_s = IDLE;
            end
         end
         ACCUM: begin
            if (!win_done_s) begin
               state_s = ACCUM;
            end else if (w_eff_s < EMPTY_TH_C) begin
               state_s   = IDLE;
               m_s       = {MW{1'b0}};
               prev_ok_s = 1'b0;
            end else begin
               if (prev_ok_r && (abs_diff(w_eff_s, prev_avg_r) <= TOL_C)) begin
                  m_s = m_r + MW'(1);
               end else begin
                  m_s = {MW{1'b0}};
               end
               prev_avg_s = w_eff_s;
               prev_ok_s  = 1'b1;
               if (m_s == STABLE_C) begin
                  state_s  = LOCKED;
                  weight_s = w_eff_s;
                  height_s = h_avg_s;
                  strobe_s = 1'b1;
               end else begin
                  state_s = ACCUM;
               end
            end
         end
         LOCKED: begin
            if (!win_done_s) begin
               state_s = LOCKED;
            end else if (w_eff_s < EMPTY_TH_C) begin
               state_s   = IDLE;
               m_s       = {MW{1'b0}};
               prev_ok_s = 1'b0;
            end else if (abs_diff(w_eff_s, weight_r) > TOL_C) begin
               state_s    = ACCUM;
               m_s        = {MW{1'b0}};
               prev_avg_s = w_eff_s;
               prev_ok_s  = 1'b1;
            end else begin
               state_s = LOCKED;
            end
         end
         default: begin
            state_s = IDLE;
         end
      endcase
   end

   // State and registered outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_r       <= IDLE;
         m_r           <= {MW{1'b0}};
         prev_avg_r    <= {W_W{1'b0}};
         prev_ok_r     <= 1'b0;
         weight_r      <= {W_W{1'b0}};
         height_r      <= {H_W{1'b0}};
         meas_valid_r  <= 1'b0;
         meas_strobe_r <= 1'b0;
         busy_r        <= 1'b0;
         tare_arm_r    <= 1'b0;
         tare_off_r    <= {W_W{1'b0}};
      end else begin
         state_r       <= state_s;
         m_r           <= m_s;
         prev_avg_r    <= prev_avg_s;
         prev_ok_r     <= prev_ok_s;
         weight_r      <= weight_s;
         height_r      <= height_s;
         meas_valid_r  <= (state_s == LOCKED);
         meas_strobe_r <= strobe_s;
         busy_r        <= (state_s != IDLE);
         tare_arm_r    <= tare_arm_s;
         tare_off_r    <= tare_off_s;
      end
   end

   assign weight      = weight_r;
   assign height      = height_r;
   assign meas_valid  = meas_valid_r;
   assign meas_strobe = meas_strobe_r;
   assign busy        = busy_r;

endmodule

// File: doc/smart_scales_frontend.md
Name: smart_scales_frontend

Overview:
- Upstream acquisition stage for smart_scales_system.
- Takes raw weight and height samples from the load-cell and height-sensor interfaces.
- Averages the samples over fixed windows and waits until the weight settles.
- Then presents one locked weight/height measurement, with valid and strobe, to the BMI/range logic downstream.

Parameters:
- AVG_LOG2, 2: window length is 2^AVG_LOG2 samples.
- TOL, 2: maximum difference between consecutive window weight averages that still counts as a match.
- STABLE_WIN, 3: number of consecutive matching windows required to lock.
- EMPTY_TH, 10: weight average below this value means the platform is empty.

Ports:
- clk  in  1  system clock; every flop is rising-edge.
- rst_n  in  1  synchronous, active-low reset.
- sample_valid  in  1  qualifies w_sample/h_sample for one cycle.
- w_sample  in  9  raw weight sample, unsigned.
- h_sample  in  8  raw height sample, unsigned.
- weight  out  9  locked weight average.
- height  out  8  locked height average.
- meas_valid  out  1  high while in LOCKED.
- meas_strobe  out  1  one-cycle pulse on entry to LOCKED.
- busy  out  1  high when state is not IDLE.

Behaviour:
- Reset: synchronous, active-low, wins over every other event. Next edge gives state IDLE; weight, height, meas_valid, meas_strobe, busy, accumulators, counters, prev_avg and match count M all 0.
- There is no back-pressure. Every sample_valid cycle is consumed in ACCUM and LOCKED.
- Accumulators are 9+AVG_LOG2 bits (weight) and 8+AVG_LOG2 bits (height). Window average = accumulator >> AVG_LOG2 (truncation).
- Window completes on the cycle of its 2^AVG_LOG2-th sample. All consequences (state change, outputs) are registered and visible one clock later.
- IDLE:
  - sample_valid with w_sample < EMPTY_TH: ignored.
  - sample_valid with w_sample >= EMPTY_TH: that sample starts a window; state goes to ACCUM; M=0; prev_avg marked invalid.
- ACCUM, on each window completion:
  - Average weight < EMPTY_TH: go to IDLE, clear accumulators and M.
  - No valid prev_avg: M=0.
  - |avg - prev_avg| <= TOL: M++.
  - Otherwise: M=0.
  - prev_avg <= avg.
  - If M reaches STABLE_WIN: go to LOCKED; load weight/height with this window's averages; pulse meas_strobe.
  - The next window starts on the following sample (back-to-back windows, no gap).
- LOCKED: meas_valid=1. Windows keep running; on each window completion:
  - Average weight < EMPTY_TH: go to IDLE; meas_valid falls.
  - |avg - weight| > TOL: go to ACCUM; M=0; prev_avg=avg; meas_valid falls.
  - Otherwise: stay in LOCKED; outputs unchanged (no refresh, no new strobe).
- weight/height keep their last locked values after leaving LOCKED, until the next lock or reset.
- Full-scale input w_sample=511 must not overflow: accumulator width is sufficient by construction.
- Reset asserted mid-window: partial sums discarded.

Optional Feature:
- SCALE_TARE_EN defined:
  - Adds input port tare (1 bit) and a 9-bit tare_off register, reset value 0.
  - A tare pulse in IDLE arms a capture. The next completed window average, taken regardless of EMPTY_TH, is loaded into tare_off; no state change.
  - In ACCUM and LOCKED, every window weight average has tare_off subtracted first, saturating at 0. The threshold, tolerance and output paths then use the result.
  - tare is ignored outside IDLE.
- SCALE_TARE_EN undefined: no tare port; tare_off is effectively 0.

Decomposition:
- smart_scales_pkg holds:
  - State encoding: IDLE=2'd0, ACCUM=2'd1, LOCKED=2'd2.
  - Width constants W_W=9, H_W=8, shared with smart_scales_system.
- One sub-module, window_averager:
  - Contains the sample counter and both accumulators.
  - Outputs win_done (1-cycle) plus w_avg and h_avg.
  - Parent holds the FSM, match logic and output registers.

Test Plan (default parameters):
- Reset mid-ACCUM: rst_n low one edge after 2 samples of 331 -> all outputs 0, busy=0. A fresh 16-sample run of 331 is then still required to lock.
- Steady input: 16 samples w=331, h=170 -> one clock after the 16th sample:
  - meas_strobe=1 for exactly one cycle.
  - meas_valid=1, weight=331, height=170.
- Settling: window averages 80, 83, 83, 84, 85 -> M goes 0, 0, 1, 2, 3; lock after the 5th window with weight=85. No lock earlier.
- Truncation: window samples 100, 101, 101, 101 (x4 windows) -> locked weight=100.
- Step-off: locked at 331, then 4 samples w=0 -> meas_valid=0, busy=0, weight still 331.
- Noise in IDLE: samples w=5 repeated 20 times -> busy stays 0, no strobe. A jump to 200 while LOCKED at 100 re-enters ACCUM with meas_valid=0.
